// File: rtl/wr_flow_ctrl_pkg.sv
// Shared defaults and pointer helpers for the write-side flow controller.
// gray2bin works on a wide vector so any pointer width can zero-extend into it.
package wr_flow_ctrl_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_PTR_WIDTH  = 3;
  localparam int GRAY_MAX_WIDTH = 16;

  // Leading zeros of a zero-extended Gray code decode to leading zeros,
  // so narrower pointers can simply be widened, decoded and truncated.
  function automatic logic [GRAY_MAX_WIDTH-1:0] gray2bin(input logic [GRAY_MAX_WIDTH-1:0] gray);
    logic [GRAY_MAX_WIDTH-1:0] bin;
    bin[GRAY_MAX_WIDTH-1] = gray[GRAY_MAX_WIDTH-1];
    for (int i = GRAY_MAX_WIDTH - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/wr_skid_buf.sv
// Two-entry main/skid register pair that keeps s_ready registered while the
// FIFO write side stalls on full.
module wr_skid_buf
  import wr_flow_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  wclk,
  input  logic                  wrst_n,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  s_ready,
  input  logic                  full,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data
);

  logic                  k_valid;
  logic [DATA_WIDTH-1:0] k_data;
  logic                  m_valid_next;
  logic                  k_valid_next;
  logic [DATA_WIDTH-1:0] m_data_next;
  logic [DATA_WIDTH-1:0] k_data_next;
  logic                  accept;
  logic                  drain;

  assign accept = s_valid & s_ready;
  assign drain  = m_valid & ~full;

  // The skid word always has priority for the main slot so ordering is kept.
  always_comb begin
    m_valid_next = m_valid;
    k_valid_next = k_valid;
    m_data_next  = m_data;
    k_data_next  = k_data;
    if (!m_valid || drain) begin
      if (k_valid) begin
        m_data_next  = k_data;
        k_valid_next = 1'b0;
      end else if (accept) begin
        m_data_next  = s_data;
        m_valid_next = 1'b1;
      end else begin
        m_valid_next = 1'b0;
      end
    end else if (accept) begin
      k_data_next  = s_data;
      k_valid_next = 1'b1;
    end
  end

  always_ff @(posedge wclk) begin
    if (!wrst_n) begin
      m_valid <= 1'b0;
      k_valid <= 1'b0;
      s_ready <= 1'b0;
    end else begin
      m_valid <= m_valid_next;
      k_valid <= k_valid_next;
      s_ready <= ~k_valid_next;
    end
  end

  // Payload registers need no reset; their valid bits qualify them.
  always_ff @(posedge wclk) begin
    m_data <= m_data_next;
    k_data <= k_data_next;
  end

endmodule

// File: rtl/wr_flow_ctrl.sv
// Write-side flow controller: buffers the producer stream, strobes the FIFO
// when not full and reports fill level, almost_full and a running write count.
module wr_flow_ctrl
  import wr_flow_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int PTR_WIDTH  = DEF_PTR_WIDTH,
  parameter int AF_THRESH  = 6,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  wclk,
  input  logic                  wrst_n,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  s_ready,
  input  logic                  full,
  input  logic [PTR_WIDTH:0]    b_wptr,
  input  logic [PTR_WIDTH:0]    g_rptr_sync,
  output logic                  w_en,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic [PTR_WIDTH:0]    wlevel,
  output logic                  almost_full,
  output logic [CNT_WIDTH-1:0]  wr_count
);

  localparam logic [PTR_WIDTH:0] AF_LEVEL = (PTR_WIDTH+1)'(AF_THRESH);

  logic               m_valid;
  logic [PTR_WIDTH:0] rptr_bin;
  logic [PTR_WIDTH:0] wlevel_next;

  wr_skid_buf #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_skid (
    .wclk    (wclk),
    .wrst_n  (wrst_n),
    .s_valid (s_valid),
    .s_data  (s_data),
    .s_ready (s_ready),
    .full    (full),
    .m_valid (m_valid),
    .m_data  (wdata)
  );

  assign w_en = m_valid & ~full;

  // Modular subtract absorbs pointer wrap; a stale read pointer only over-reports.
  assign rptr_bin    = (PTR_WIDTH+1)'(gray2bin(GRAY_MAX_WIDTH'(g_rptr_sync)));
  assign wlevel_next = b_wptr - rptr_bin;

  always_ff @(posedge wclk) begin
    if (!wrst_n) begin
      wlevel      <= '0;
      almost_full <= 1'b0;
      wr_count    <= '0;
    end else begin
      wlevel      <= wlevel_next;
      almost_full <= (wlevel_next >= AF_LEVEL);
      if (w_en) begin
        wr_count <= wr_count + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_wr_flow_ctrl.sv
// Self-checking bench for wr_flow_ctrl: directed scenarios followed by random
// traffic, all compared against a queue-based reference model.
module tb_wr_flow_ctrl;

  localparam int DW = 8;
  localparam int PW = 3;
  localparam int AF = 6;
  localparam int CW = 16;

  logic          wclk = 1'b0;
  logic          wrst_n;
  logic          s_valid;
  logic [DW-1:0] s_data;
  logic          s_ready;
  logic          full;
  logic [PW:0]   b_wptr;
  logic [PW:0]   g_rptr_sync;
  logic          w_en;
  logic [DW-1:0] wdata;
  logic [PW:0]   wlevel;
  logic          almost_full;
  logic [CW-1:0] wr_count;

  always #5 wclk = ~wclk;

  wr_flow_ctrl #(
    .DATA_WIDTH(DW),
    .PTR_WIDTH (PW),
    .AF_THRESH (AF),
    .CNT_WIDTH (CW)
  ) dut (
    .wclk        (wclk),
    .wrst_n      (wrst_n),
    .s_valid     (s_valid),
    .s_data      (s_data),
    .s_ready     (s_ready),
    .full        (full),
    .b_wptr      (b_wptr),
    .g_rptr_sync (g_rptr_sync),
    .w_en        (w_en),
    .wdata       (wdata),
    .wlevel      (wlevel),
    .almost_full (almost_full),
    .wr_count    (wr_count)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: buffered words as a FIFO queue of capacity two.
  logic [DW-1:0] mq[$];
  logic          m_rdy = 1'b0;
  logic [PW:0]   m_lvl = '0;
  logic          m_af  = 1'b0;
  logic [CW-1:0] m_cnt = '0;
  bit            live  = 1'b0;

  logic [DW-1:0] src[$];
  logic [DW-1:0] dut_log[$];
  int            wen_cyc[$];
  int            acc_count = 0;
  int            cyc_no = 0;

  function automatic logic [PW:0] bin2gray(input logic [PW:0] b);
    return b ^ (b >> 1);
  endfunction

  // Decode by searching for the code that matches, independent of any XOR chain.
  function automatic logic [PW:0] gray_lut(input logic [PW:0] g);
    logic [PW:0] b;
    for (int i = 0; i < (1 << (PW + 1)); i++) begin
      b = i[PW:0];
      if ((b ^ (b >> 1)) == g) return b;
    end
    return '0;
  endfunction

  task automatic check1(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic v, input logic [DW-1:0] d,
                               input logic f, input logic [PW:0] bw, input logic [PW:0] rbin);
    wrst_n      = rst;
    s_valid     = v;
    s_data      = d;
    full        = f;
    b_wptr      = bw;
    g_rptr_sync = bin2gray(rbin);
  endtask

  task automatic checkOutput();
    logic exp_wen;
    if (!live) return;
    exp_wen = (mq.size() > 0) && !full;
    check1("s_ready", s_ready, m_rdy);
    check1("w_en", w_en, exp_wen);
    if (exp_wen) check1("wdata", wdata, mq[0]);
    check1("wlevel", wlevel, m_lvl);
    check1("almost_full", almost_full, m_af);
    check1("wr_count", wr_count, m_cnt);
  endtask

  task automatic modelEdge();
    logic wen;
    logic acc;
    if (!wrst_n) begin
      mq.delete();
      m_rdy = 1'b0;
      m_lvl = '0;
      m_af  = 1'b0;
      m_cnt = '0;
      live  = 1'b1;
    end else begin
      wen = (mq.size() > 0) && !full;
      acc = s_valid && m_rdy;
      if (wen) begin
        void'(mq.pop_front());
        m_cnt = m_cnt + 1'b1;
      end
      if (acc) begin
        mq.push_back(s_data);
        if (src.size() > 0) void'(src.pop_front());
      end
      m_rdy = (mq.size() < 2);
      m_lvl = b_wptr - gray_lut(g_rptr_sync);
      m_af  = (m_lvl >= AF);
    end
  endtask

  task automatic cycle();
    @(negedge wclk);
    checkOutput();
    if (live && w_en === 1'b1) begin
      dut_log.push_back(wdata);
      wen_cyc.push_back(cyc_no);
    end
    if (live && wrst_n && s_valid && s_ready === 1'b1) acc_count++;
    modelEdge();
    @(posedge wclk);
    #1;
    cyc_no++;
  endtask

  task automatic streamStep(input logic f);
    applyStimulus(1'b1, src.size() > 0, (src.size() > 0) ? src[0] : '0, f, '0, '0);
    cycle();
  endtask

  initial begin
    logic [DW-1:0] obs;

    // Reset held for three cycles with a valid producer.
    applyStimulus(1'b0, 1'b1, 8'hAA, 1'b0, '0, '0);
    repeat (3) cycle();
    check1("rst_w_en", w_en, 1'b0);
    check1("rst_s_ready", s_ready, 1'b0);
    check1("rst_wlevel", wlevel, 0);
    check1("rst_wr_count", wr_count, 0);

    // Streaming 0x01..0x08 with full low.
    for (int i = 1; i <= 8; i++) src.push_back(DW'(i));
    dut_log.delete();
    wen_cyc.delete();
    streamStep(1'b0);
    check1("ready_after_release", s_ready, 1'b1);
    repeat (11) streamStep(1'b0);
    check1("stream_count", dut_log.size(), 8);
    for (int i = 0; i < 8; i++) begin
      obs = (i < dut_log.size()) ? dut_log[i] : 'x;
      check1("stream_order", obs, i + 1);
    end
    check1("stream_consecutive", (wen_cyc.size() == 8) ? (wen_cyc[7] - wen_cyc[0]) : -1, 7);
    check1("stream_wr_count", wr_count, 8);

    // Backpressure: full rises once the first word is in the main slot.
    src.delete();
    for (int i = 1; i <= 5; i++) src.push_back(DW'(i));
    dut_log.delete();
    streamStep(1'b0);
    acc_count = 0;
    streamStep(1'b0);
    repeat (4) streamStep(1'b1);
    check1("bp_accepted", acc_count, 2);
    check1("bp_s_ready", s_ready, 1'b0);
    check1("bp_w_en", w_en, 1'b0);
    repeat (8) streamStep(1'b0);
    check1("bp_count", dut_log.size(), 5);
    for (int i = 0; i < 5; i++) begin
      obs = (i < dut_log.size()) ? dut_log[i] : 'x;
      check1("bp_order", obs, i + 1);
    end

    // Level wrap-around and full-depth level.
    applyStimulus(1'b1, 1'b0, '0, 1'b0, 4'b0001, 4'd15);
    cycle();
    check1("wrap_level", wlevel, 2);
    check1("wrap_af", almost_full, 1'b0);
    applyStimulus(1'b1, 1'b0, '0, 1'b0, 4'b1000, 4'd0);
    cycle();
    check1("depth_level", wlevel, 8);
    check1("depth_af", almost_full, 1'b1);

    // Threshold sweep 5 -> 6 -> 5.
    applyStimulus(1'b1, 1'b0, '0, 1'b0, 4'd5, 4'd0);
    cycle();
    check1("thr5_af", almost_full, 1'b0);
    applyStimulus(1'b1, 1'b0, '0, 1'b0, 4'd6, 4'd0);
    cycle();
    check1("thr6_level", wlevel, 6);
    check1("thr6_af", almost_full, 1'b1);
    applyStimulus(1'b1, 1'b0, '0, 1'b0, 4'd5, 4'd0);
    cycle();
    check1("thr5b_level", wlevel, 5);
    check1("thr5b_af", almost_full, 1'b0);

    // Mid-operation reset with both registers occupied.
    src.delete();
    src.push_back(8'hC1);
    src.push_back(8'hC2);
    dut_log.delete();
    repeat (3) streamStep(1'b1);
    check1("midrst_pre_ready", s_ready, 1'b0);
    applyStimulus(1'b0, 1'b0, '0, 1'b1, '0, '0);
    cycle();
    check1("midrst_w_en", w_en, 1'b0);
    applyStimulus(1'b1, 1'b0, '0, 1'b0, '0, '0);
    repeat (4) cycle();
    check1("midrst_no_writes", dut_log.size(), 0);
    check1("midrst_wr_count", wr_count, 0);

    // Random traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 49) != 0, $urandom_range(0, 3) != 0, DW'($urandom),
                    $urandom_range(0, 2) == 0, (PW+1)'($urandom), (PW+1)'($urandom));
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/wr_flow_ctrl.md
Name: wr_flow_ctrl

Overview:
Write-side flow controller that sits directly upstream of the FIFO write-pointer handler in the wclk domain.
- Accepts a valid/ready stream from the producer.
- Buffers up to two words in a main register plus a skid register, so s_ready is registered.
- Drives w_en/wdata only when the FIFO is not full.
- Reports write-side fill level, almost_full and a running write count, computed from b_wptr and the synchronised Gray read pointer.

Parameters:
DATA_WIDTH, 8, width of s_data/wdata
PTR_WIDTH, 3, FIFO address width; pointers are PTR_WIDTH+1 bits, depth = 2^PTR_WIDTH
AF_THRESH, 6, wlevel at or above which almost_full asserts (1..2^PTR_WIDTH)
CNT_WIDTH, 16, width of wr_count

Ports:
wclk  input  1  write-domain clock
wrst_n  input  1  reset, synchronous, active-low
s_valid  input  1  producer word valid
s_data  input  DATA_WIDTH  producer word
s_ready  output  1  registered ready to producer
full  input  1  FIFO full flag from write-pointer handler
b_wptr  input  PTR_WIDTH+1  binary write pointer from write-pointer handler
g_rptr_sync  input  PTR_WIDTH+1  Gray read pointer, already synchronised into wclk
w_en  output  1  write strobe to FIFO/pointer handler
wdata  output  DATA_WIDTH  write data to FIFO memory
wlevel  output  PTR_WIDTH+1  registered fill level, 0..2^PTR_WIDTH
almost_full  output  1  registered, wlevel_next >= AF_THRESH
wr_count  output  CNT_WIDTH  total words written, wraps

Behaviour:
- Clocking and reset:
  - Single clock wclk; reset is synchronous, active-low (wrst_n sampled only on posedge wclk).
  - Reset clears m_valid, k_valid, s_ready, wlevel, almost_full and wr_count to 0. m_data/k_data are don't-care.
  - Mid-operation reset discards any buffered words. w_en is 0 from the reset edge on.
- Definitions: accept = s_valid & s_ready; drain = m_valid & !full.
- Output strobe:
  - w_en = m_valid & !full (combinational), so w_en is never 1 while full = 1.
  - wdata = m_data.
- Main register, updated when !m_valid | drain:
  - If k_valid: m <= k, k_valid <= 0.
  - Else if accept: m <= s_data, m_valid <= 1.
  - Else: m_valid <= 0.
- Stall case (m_valid & full):
  - If accept: k <= s_data, k_valid <= 1. m is held.
- Ready:
  - s_ready <= !k_valid_next.
  - accept cannot occur while k_valid = 1.
  - First cycle after reset release: s_ready = 0; 1 from the following cycle.
- Ordering and latency:
  - Words are strictly in order; none dropped or duplicated.
  - A word accepted at edge N is presented with w_en at cycle N+1 at the earliest.
  - Sustained throughput is 1 word/cycle while full = 0.
- Level:
  - rptr_bin = gray2bin(g_rptr_sync).
  - wlevel <= (b_wptr - rptr_bin) mod 2^(PTR_WIDTH+1), registered.
  - Wrap-around is handled by the modular subtract, e.g. b_wptr = 4'b0001 and rptr_bin = 4'b1111 gives wlevel = 2.
  - The level is conservative (over-reports) because of read-pointer sync latency.
- almost_full <= (wlevel_next >= AF_THRESH).
- wr_count increments by 1 on every cycle with w_en = 1 and wraps from all-ones to 0.
- Simultaneous drain and accept with k empty: m reloads from s_data in the same edge; k is untouched.

Decomposition:
- Shared package holds:
  - PTR_WIDTH and DATA_WIDTH defaults
  - the gray2bin function (Gray to binary, PTR_WIDTH+1 bits)
- Natural sub-module: wr_skid_buf, containing the main register, skid register and s_ready logic.
- The level, almost_full and count logic stay in wr_flow_ctrl.

Test Plan:
- Reset and ready: hold wrst_n = 0 for 3 cycles, s_valid = 1 → w_en = 0, s_ready = 0, wlevel = 0, wr_count = 0; s_ready = 1 on the second cycle after release.
- Streaming: full = 0, send 0x01..0x08 back-to-back → wdata = 0x01..0x08 in order, w_en high 8 consecutive cycles, wr_count = 8.
- Backpressure: raise full after the first word, keep s_valid = 1 → exactly 2 more words accepted, then s_ready = 0 and w_en = 0. Drop full → 0x02, 0x03 emerge in order with no loss.
- Level wrap: b_wptr = 4'b0001, g_rptr_sync = 4'b1000 (bin 15) → wlevel = 2 next cycle; b_wptr = 4'b1000, g_rptr_sync = 0 → wlevel = 8, almost_full = 1.
- Threshold: AF_THRESH = 6, sweep wlevel 5→6→5 → almost_full goes 0→1→0, aligned with wlevel.
- Mid-op reset: two words buffered with full = 1, pulse wrst_n = 0 for 1 cycle → k_valid = m_valid = 0, w_en = 0, buffered words never written, wr_count = 0.
